// File: rtl/onehot_history_display.sv
// One-hot code consumer: validates and decodes the code, keeps a 4-deep change history
// and scans it onto a 4-digit common-anode 7-segment display (digit0 = newest).
module onehot_history_display #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       code_in,
  output logic [3:0]       an,
  output logic [6:0]       seg_out,
  output logic             err,
  output logic [CNT_W-1:0] chg_cnt
);
  localparam int               PRE_W   = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0]       r_in_q;
  logic             r_in_vld;
  logic [2:0]       r_hist [4];
  logic [3:0]       r_vld;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_sel;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic [2:0]       w_val;
  logic             w_multi;
  logic             w_seen;
  logic             w_push;
  logic [6:0]       w_seg_next;

  function automatic logic [6:0] glyph(input logic [2:0] v);
    case (v)
      3'd0:    glyph = 7'b1000000;
      3'd1:    glyph = 7'b1111001;
      3'd2:    glyph = 7'b0100100;
      3'd3:    glyph = 7'b0110000;
      3'd4:    glyph = 7'b0011001;
      3'd5:    glyph = 7'b0010010;
      3'd6:    glyph = 7'b0000010;
      default: glyph = 7'b1111000;
    endcase
  endfunction

  // Decode: last set bit wins for the value; a second set bit marks the code illegal.
  always_comb begin
    w_val   = 3'd0;
    w_multi = 1'b0;
    w_seen  = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (r_in_q[k]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
        w_val  = 3'(k + 1);
      end
    end
  end

  // r_in_vld keeps the flushed post-reset in_q from pushing a spurious 0.
  assign w_push     = r_in_vld && !w_multi && (!r_vld[0] || (w_val != r_hist[0]));
  assign w_seg_next = r_vld[r_sel] ? glyph(r_hist[r_sel]) : 7'h7F;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q   <= 7'd0;
      r_in_vld <= 1'b0;
      for (int i = 0; i < 4; i++) r_hist[i] <= 3'd0;
      r_vld    <= 4'd0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_pre    <= '0;
      r_sel    <= 2'd0;
      r_an     <= 4'b1111;
      r_seg    <= 7'h7F;
    end else begin
      r_in_q   <= code_in;
      r_in_vld <= 1'b1;

      if (r_in_vld && w_multi) r_err <= 1'b1;

      if (w_push) begin
        r_hist[3] <= r_hist[2];
        r_hist[2] <= r_hist[1];
        r_hist[1] <= r_hist[0];
        r_hist[0] <= w_val;
        r_vld     <= {r_vld[2:0], 1'b1};
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end

      if (r_pre == PRE_MAX) begin
        r_pre <= '0;
        r_sel <= r_sel + 2'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end

      r_an  <= ~(4'b0001 << r_sel);
      r_seg <= w_seg_next;
    end
  end

  assign an      = r_an;
  assign seg_out = r_seg;
  assign err     = r_err;
  assign chg_cnt = r_cnt;
endmodule

// File: tb/tb_onehot_history_display.sv
// Bench for onehot_history_display: directed steps plus random codes, every cycle
// compared against a queue-based model of the change history and scan timing.
module tb_onehot_history_display;
  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 8;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [6:0]       code_in;
  logic [3:0]       an;
  logic [6:0]       seg_out;
  logic             err;
  logic [CNT_W-1:0] chg_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  onehot_history_display #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .code_in (code_in),
    .an      (an),
    .seg_out (seg_out),
    .err     (err),
    .chg_cnt (chg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: history as a queue of values, newest at the front
  logic [6:0] glyph_t [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
  int         hist_q[$];
  logic [6:0] m_pipe;
  bit         m_pipe_v;
  int         m_cnt;
  bit         m_err;
  int         m_k;
  logic [3:0] e_an;
  logic [6:0] e_seg;

  task automatic model_edge();
    int sel, ones, v;
    if (rst) begin
      hist_q.delete();
      m_pipe_v = 0;
      m_cnt    = 0;
      m_err    = 0;
      m_k      = 0;
      e_an     = 4'b1111;
      e_seg    = 7'h7F;
    end else begin
      sel   = (m_k / SCAN_DIV) % 4;
      e_an  = ~(4'b0001 << sel);
      e_seg = (sel < hist_q.size()) ? glyph_t[hist_q[sel]] : 7'h7F;
      if (m_pipe_v) begin
        ones = $countones(m_pipe);
        if (ones > 1) m_err = 1;
        else begin
          v = 0;
          for (int j = 0; j < 7; j++) if (m_pipe[j]) v = j + 1;
          if (hist_q.size() == 0 || v != hist_q[0]) begin
            hist_q.push_front(v);
            if (hist_q.size() > 4) void'(hist_q.pop_back());
            if (m_cnt < CNT_SAT) m_cnt++;
          end
        end
      end
      m_pipe   = code_in;
      m_pipe_v = 1;
      m_k++;
    end
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("an", 32'(an), 32'(e_an));
    check("seg_out", 32'(seg_out), 32'(e_seg));
    check("err", 32'(err), 32'(m_err));
    check("chg_cnt", 32'(chg_cnt), 32'(m_cnt));
  endtask

  // driver: apply inputs, take one edge, update model, sample 1 time unit later
  task automatic cyc(input logic [6:0] c, input logic r);
    code_in = c;
    rst     = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [6:0] c, input int n);
    for (int i = 0; i < n; i++) cyc(c, 1'b0);
  endtask

  function automatic logic [6:0] rand_legal();
    int v;
    v = $urandom_range(0, 7);
    return (v == 0) ? 7'd0 : 7'(1 << (v - 1));
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] c;
    int a, b;
    a = $urandom_range(0, 6);
    b = (a + $urandom_range(1, 6)) % 7;
    c = 7'(1 << a) | 7'(1 << b) | 7'($urandom_range(0, 127));
    return c;
  endfunction

  initial begin
    code_in = 7'h7F;
    rst     = 1'b1;
    m_pipe  = 7'd0;

    // 1. reset with an illegal code on the input
    cyc(7'h7F, 1'b1);
    cyc(7'h7F, 1'b1);
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg_out), 32'h0000007F);

    // 2. first value, two-edge latency
    cyc(7'b0000001, 1'b0);
    check("lat1_cnt", 32'(chg_cnt), 32'd0);
    cyc(7'b0000001, 1'b0);
    check("lat2_cnt", 32'(chg_cnt), 32'd1);

    // 3. repeats never push, then four changes
    hold(7'b0000001, 20);
    check("repeat_cnt", 32'(chg_cnt), 32'd1);
    hold(7'b0000100, 3);
    hold(7'b0001000, 3);
    hold(7'b0100000, 3);
    hold(7'b1000000, 3);
    hold(7'b1000000, 2 * SCAN_DIV * 4);
    check("four_cnt", 32'(chg_cnt), 32'd5);

    // 4. illegal code sets sticky err without pushing
    hold(7'b0000011, 2);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_cnt", 32'(chg_cnt), 32'd5);
    hold(7'b0000010, 3);
    check("after_err_cnt", 32'(chg_cnt), 32'd6);
    check("err_sticky", 32'(err), 32'd1);

    // 5. free-run scan
    hold(7'b0000010, 3 * SCAN_DIV * 4);

    // 6. saturate the change counter, then one-edge reset
    for (int i = 0; i < 300; i++) cyc((i % 2 == 0) ? 7'b0000001 : 7'b0000010, 1'b0);
    hold(7'b0000010, 2);
    check("sat_cnt", 32'(chg_cnt), 32'd255);
    cyc(7'b0000100, 1'b1);
    check("rst2_cnt", 32'(chg_cnt), 32'd0);
    check("rst2_err", 32'(err), 32'd0);

    // random legal codes with repeats, mid-run reset, then random with illegal codes
    for (int i = 0; i < 150; i++) hold(rand_legal(), $urandom_range(1, 3));
    cyc(7'b0010000, 1'b0);
    cyc(7'b0001000, 1'b1);
    cyc(7'b0001000, 1'b0);
    check("flush_cnt", 32'(chg_cnt), 32'd0);
    for (int i = 0; i < 150; i++)
      hold(($urandom_range(0, 15) == 0) ? rand_illegal() : rand_legal(), $urandom_range(1, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
